syn_audio_cache: RTL

- PCM buffering stage between the Acortex fabric and the WM8731 driver.
- DAC path: stores stereo samples from an upstream producer and presents them to the driver ingress handshake (valid/ack).
- ADC path: captures each stereo sample the driver emits on its egress valid pulse and presents it to a downstream consumer (valid/ready).
- A local-bus slave exposes fill levels, sticky error flags and flush controls.

---
 rtl/syn_audio_cache_pkg.sv | 19 +
 rtl/syn_audio_cache_if.sv | 58 +++++
 rtl/syn_audio_cache_fifo.sv | 55 +++++
 rtl/syn_audio_cache.sv | 133 +++++++++++++
 4 files changed

// File: rtl/syn_audio_cache_pkg.sv
// Shared types and local-bus register map for the Acortex PCM buffering stage.
package syn_audio_cache_pkg;

    localparam int PCM_W_DEF = 32;
    localparam int DEPTH_DEF = 128;

    typedef struct packed {
        logic [PCM_W_DEF-1:0] lchnnl;
        logic [PCM_W_DEF-1:0] rchnnl;
    } pcm_sample_t;

    localparam logic [7:0] ACORTEX_ACACHE_CTRL_REG_ADDR     = 8'h20;
    localparam logic [7:0] ACORTEX_ACACHE_STATUS_REG_ADDR   = 8'h21;
    localparam logic [7:0] ACORTEX_ACACHE_DAC_FILL_REG_ADDR = 8'h22;
    localparam logic [7:0] ACORTEX_ACACHE_ADC_FILL_REG_ADDR = 8'h23;

    localparam logic [15:0] ACORTEX_ACACHE_BAD_ADDR_DATA = 16'hdead;

endpackage

// File: rtl/syn_audio_cache_if.sv
// Local-bus, DAC stream and ADC stream signals of the PCM cache in one bundle.
interface syn_audio_cache_if #(
    parameter int P_PCM_W     = 32,
    parameter int P_LB_ADDR_W = 8,
    parameter int P_LB_DATA_W = 16
);

    logic                   lb_wr_en;
    logic                   lb_rd_en;
    logic [P_LB_ADDR_W-1:0] lb_addr;
    logic [P_LB_DATA_W-1:0] lb_wr_data;
    logic                   lb_wr_valid;
    logic                   lb_rd_valid;
    logic [P_LB_DATA_W-1:0] lb_rd_data;

    logic                   dac_in_valid;
    logic                   dac_in_ready;
    logic [P_PCM_W-1:0]     dac_in_ldata;
    logic [P_PCM_W-1:0]     dac_in_rdata;
    logic                   drvr_pcm_valid;
    logic                   drvr_ack;
    logic [P_PCM_W-1:0]     drvr_ldata;
    logic [P_PCM_W-1:0]     drvr_rdata;

    logic                   adc_in_valid;
    logic [P_PCM_W-1:0]     adc_in_ldata;
    logic [P_PCM_W-1:0]     adc_in_rdata;
    logic                   adc_out_valid;
    logic                   adc_out_ready;
    logic [P_PCM_W-1:0]     adc_out_ldata;
    logic [P_PCM_W-1:0]     adc_out_rdata;

    // The master side stands for every peer: fabric, producer, driver and consumer.
    modport master (
        output lb_wr_en, lb_rd_en, lb_addr, lb_wr_data,
        input  lb_wr_valid, lb_rd_valid, lb_rd_data,
        output dac_in_valid, dac_in_ldata, dac_in_rdata,
        input  dac_in_ready,
        input  drvr_pcm_valid, drvr_ldata, drvr_rdata,
        output drvr_ack,
        output adc_in_valid, adc_in_ldata, adc_in_rdata,
        input  adc_out_valid, adc_out_ldata, adc_out_rdata,
        output adc_out_ready
    );

    modport slave (
        input  lb_wr_en, lb_rd_en, lb_addr, lb_wr_data,
        output lb_wr_valid, lb_rd_valid, lb_rd_data,
        input  dac_in_valid, dac_in_ldata, dac_in_rdata,
        output dac_in_ready,
        output drvr_pcm_valid, drvr_ldata, drvr_rdata,
        input  drvr_ack,
        input  adc_in_valid, adc_in_ldata, adc_in_rdata,
        output adc_out_valid, adc_out_ldata, adc_out_rdata,
        input  adc_out_ready
    );

endinterface

// File: rtl/syn_audio_cache_fifo.sv
// First-word-fall-through synchronous FIFO with flush and fill-count output.
module syn_audio_cache_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 128,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             wr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign pop     = rd & ~empty & ~flush;
    // A pop in the same cycle frees the slot, so a full FIFO may still take a push.
    assign push    = wr & (~full | pop) & ~flush;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/syn_audio_cache.sv
// PCM buffering between the Acortex fabric and the WM8731 driver: DAC and ADC
// FWFT FIFOs plus a local-bus block for fill levels, sticky errors and flushes.
module syn_audio_cache
    import syn_audio_cache_pkg::*;
#(
    parameter int P_PCM_W     = PCM_W_DEF,
    parameter int P_DEPTH     = DEPTH_DEF,
    parameter int P_LB_ADDR_W = 8,
    parameter int P_LB_DATA_W = 16
) (
    input logic              clk_ir,
    input logic              rst_sync_l,
    syn_audio_cache_if.slave bus
);

    localparam int P_CNT_W = $clog2(P_DEPTH) + 1;
    localparam int ENT_W   = 2 * P_PCM_W;

    logic [ENT_W-1:0]       dac_head;
    logic [ENT_W-1:0]       adc_head;
    logic [P_CNT_W-1:0]     dac_count;
    logic [P_CNT_W-1:0]     adc_count;
    logic                   dac_empty;
    logic                   dac_full;
    logic                   adc_empty;
    logic                   adc_full;
    logic                   sel_ctrl;
    logic                   sel_status;
    logic                   sel_dac_fill;
    logic                   sel_adc_fill;
    logic                   dac_flush;
    logic                   adc_flush;
    logic                   underrun_set;
    logic                   underrun_clr;
    logic                   overrun_set;
    logic                   overrun_clr;
    logic                   dac_underrun;
    logic                   adc_overrun;
    logic [5:0]             status;
    logic [P_LB_DATA_W-1:0] rd_mux;
    logic                   wr_vld_p1;
    logic                   rd_vld_p1;
    logic [P_LB_DATA_W-1:0] rd_data_p1;
    logic                   unused_wr_data;

    assign sel_ctrl     = (bus.lb_addr == P_LB_ADDR_W'(ACORTEX_ACACHE_CTRL_REG_ADDR));
    assign sel_status   = (bus.lb_addr == P_LB_ADDR_W'(ACORTEX_ACACHE_STATUS_REG_ADDR));
    assign sel_dac_fill = (bus.lb_addr == P_LB_ADDR_W'(ACORTEX_ACACHE_DAC_FILL_REG_ADDR));
    assign sel_adc_fill = (bus.lb_addr == P_LB_ADDR_W'(ACORTEX_ACACHE_ADC_FILL_REG_ADDR));

    assign dac_flush = bus.lb_wr_en & sel_ctrl & bus.lb_wr_data[0];
    assign adc_flush = bus.lb_wr_en & sel_ctrl & bus.lb_wr_data[1];

    assign unused_wr_data = ^{bus.lb_wr_data[P_LB_DATA_W-1:6], bus.lb_wr_data[3:2]};

    syn_audio_cache_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (P_DEPTH),
        .CNT_W (P_CNT_W)
    ) u_dac_fifo (
        .clk     (clk_ir),
        .rst_n   (rst_sync_l),
        .flush   (dac_flush),
        .wr      (bus.dac_in_valid),
        .wr_data ({bus.dac_in_ldata, bus.dac_in_rdata}),
        .rd      (bus.drvr_ack),
        .rd_data (dac_head),
        .count   (dac_count),
        .empty   (dac_empty),
        .full    (dac_full)
    );

    syn_audio_cache_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (P_DEPTH),
        .CNT_W (P_CNT_W)
    ) u_adc_fifo (
        .clk     (clk_ir),
        .rst_n   (rst_sync_l),
        .flush   (adc_flush),
        .wr      (bus.adc_in_valid),
        .wr_data ({bus.adc_in_ldata, bus.adc_in_rdata}),
        .rd      (bus.adc_out_ready),
        .rd_data (adc_head),
        .count   (adc_count),
        .empty   (adc_empty),
        .full    (adc_full)
    );

    // Head data is masked while empty so stale memory never leaks onto the ports.
    assign bus.dac_in_ready   = ~dac_full;
    assign bus.drvr_pcm_valid = ~dac_empty;
    assign {bus.drvr_ldata, bus.drvr_rdata} = dac_empty ? ENT_W'(0) : dac_head;
    assign bus.adc_out_valid  = ~adc_empty;
    assign {bus.adc_out_ldata, bus.adc_out_rdata} = adc_empty ? ENT_W'(0) : adc_head;

    assign underrun_set = bus.drvr_ack & dac_empty;
    assign overrun_set  = bus.adc_in_valid & adc_full & ~bus.adc_out_ready;
    assign underrun_clr = bus.lb_wr_en & sel_status & bus.lb_wr_data[4];
    assign overrun_clr  = bus.lb_wr_en & sel_status & bus.lb_wr_data[5];

    assign status = {adc_overrun, dac_underrun, adc_full, adc_empty, dac_full, dac_empty};

    always_comb begin
        rd_mux = P_LB_DATA_W'(ACORTEX_ACACHE_BAD_ADDR_DATA);
        if (sel_ctrl)          rd_mux = '0;
        else if (sel_status)   rd_mux = P_LB_DATA_W'(status);
        else if (sel_dac_fill) rd_mux = P_LB_DATA_W'(dac_count);
        else if (sel_adc_fill) rd_mux = P_LB_DATA_W'(adc_count);
    end

    // Stage p1: registered local-bus response and sticky flags (a set beats a clear).
    always_ff @(posedge clk_ir or negedge rst_sync_l) begin
        if (!rst_sync_l) begin
            wr_vld_p1    <= 1'b0;
            rd_vld_p1    <= 1'b0;
            rd_data_p1   <= '0;
            dac_underrun <= 1'b0;
            adc_overrun  <= 1'b0;
        end else begin
            wr_vld_p1    <= bus.lb_wr_en;
            rd_vld_p1    <= bus.lb_rd_en;
            if (bus.lb_rd_en) rd_data_p1 <= rd_mux;
            dac_underrun <= underrun_set | (dac_underrun & ~underrun_clr);
            adc_overrun  <= overrun_set  | (adc_overrun  & ~overrun_clr);
        end
    end

    assign bus.lb_wr_valid = wr_vld_p1;
    assign bus.lb_rd_valid = rd_vld_p1;
    assign bus.lb_rd_data  = rd_data_p1;

endmodule
